// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-source requests and uart_tx launch/done handshake bundle
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_byte;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_byte;
    logic       req1_ready;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;

    modport master (
        output req0_valid, req0_byte, req1_valid, req1_byte, tx_active, tx_done,
        input  req0_ready, req1_ready, tx_dv, tx_byte
    );

    modport slave (
        input  req0_valid, req0_byte, req1_valid, req1_byte, tx_active, tx_done,
        output req0_ready, req1_ready, tx_dv, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-byte arbiter sharing one uart_tx between two sources
module uart_tx_arbiter #(
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 20000,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_tx_arbiter_if.slave bus,
    input  logic             clr_err_i,
    output logic             grant_o,
    output logic             busy_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);
    localparam int GAP_W    = (GAP_CLKS < 2) ? 1 : $clog2(GAP_CLKS);
    localparam int TO_W     = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS);
    localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
    localparam int TO_LAST  = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_GAP} state_e;

    state_e           state_q;
    logic             tx_dv_q;
    logic [7:0]       tx_byte_q;
    logic             grant_q;
    logic             last_grant_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    logic [GAP_W-1:0] gap_q;
    logic [TO_W-1:0]  to_q;

    logic   can_accept;
    logic   pick;
    logic   acc0;
    logic   acc1;
    state_e after_tx;

    // Readys are gated by reset so a source never sees a handshake while the block is held.
    always_comb begin
        can_accept = rst_ni && (state_q == S_IDLE) && !bus.tx_active;
        pick       = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        acc0       = can_accept && bus.req0_valid && !pick;
        acc1       = can_accept && bus.req1_valid && pick;
        after_tx   = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            gap_q        <= '0;
            to_q         <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            if (clr_err_i) begin
                err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (acc0 || acc1) begin
                        tx_byte_q    <= acc1 ? bus.req1_byte : bus.req0_byte;
                        grant_q      <= acc1;
                        last_grant_q <= acc1;
                        tx_dv_q      <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_q    <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    to_q <= to_q + TO_W'(1);
                    // A done arriving on the watchdog's last cycle still counts as a good byte.
                    if (bus.tx_done) begin
                        if (grant_q) begin
                            cnt1_q <= cnt1_q + CNT_W'(1);
                        end else begin
                            cnt0_q <= cnt0_q + CNT_W'(1);
                        end
                        gap_q   <= '0;
                        state_q <= after_tx;
                    end else if (to_q == TO_W'(TO_LAST)) begin
                        err_q   <= 1'b1;
                        gap_q   <= '0;
                        state_q <= after_tx;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_LAST)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.tx_dv      = tx_dv_q;
    assign bus.tx_byte    = tx_byte_q;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q != S_IDLE);
    assign err_timeout_o  = err_q;
    assign cnt0_o         = cnt0_q;
    assign cnt1_o         = cnt1_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int GAP = 5;
    localparam int TO  = 40;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_err = 1'b0;
    logic          grant;
    logic          busy;
    logic          err;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.GAP_CLKS(GAP), .TIMEOUT_CLKS(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus), .clr_err_i(clr_err),
        .grant_o(grant), .busy_o(busy), .err_timeout_o(err), .cnt0_o(cnt0), .cnt1_o(cnt1)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int dual = 0;
    int exp_cnt[2];
    int exp_last;

    always @(negedge clk) if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) dual++;

    function automatic int model_pick(bit v0, bit v1);
        if (v0 && v1) return 1 - exp_last;
        return v1 ? 1 : 0;
    endfunction

    function automatic void model_done(int p);
        exp_cnt[p] = (exp_cnt[p] + 1) % (1 << CW);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one byte through the arbiter and reports what was observed; callers compare.
    task automatic xfer(input bit v0, input bit v1, input logic [7:0] b0, input logic [7:0] b1,
                        input int done_at, input bit keep,
                        output int port, output logic [7:0] dv_byte, output bit dv_ok,
                        output int end_k, output int err_k);
        port = -1; dv_byte = 8'h00; dv_ok = 1'b0; end_k = -1; err_k = -1;
        bus.req0_valid = v0; bus.req1_valid = v1; bus.req0_byte = b0; bus.req1_byte = b1;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (bus.req0_ready === 1'b1) port = 0;
            else if (bus.req1_ready === 1'b1) port = 1;
            if (port >= 0) break;
            step();
        end
        if (port < 0) return;
        step();
        if (!keep) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        #1;
        dv_ok   = (bus.tx_dv === 1'b1);
        dv_byte = bus.tx_byte;
        step();
        for (int k = 0; k < TO + GAP + 20; k++) begin
            bus.tx_done = (k == done_at);
            #1;
            if (k == 0 && bus.tx_dv !== 1'b0) dv_ok = 1'b0;
            if (err === 1'b1 && err_k < 0) err_k = k;
            if (busy === 1'b0) begin
                end_k = k;
                break;
            end
            step();
        end
        bus.tx_done = 1'b0;
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        nchk++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin nfail++; $display("FAIL reset_ready: got %b%b want 00", bus.req1_ready, bus.req0_ready); end
        nchk++; if (bus.tx_dv !== 1'b0 || bus.tx_byte !== 8'h00) begin nfail++; $display("FAIL reset_tx: got dv=%b byte=%h want 0/00", bus.tx_dv, bus.tx_byte); end
        nchk++; if (grant !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin nfail++; $display("FAIL reset_flags: got g=%b b=%b e=%b want 000", grant, busy, err); end
        nchk++; if (cnt0 !== '0 || cnt1 !== '0) begin nfail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0; exp_last = 1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int p, ek, erk, d; logic [7:0] db; bit ok;
        d = $urandom_range(3, 10);
        xfer(1'b1, 1'b0, 8'hA5, 8'h00, d, 1'b0, p, db, ok, ek, erk);
        exp_last = 0; model_done(0);
        nchk++; if (p !== 0) begin nfail++; $display("FAIL single_port: got %0d want 0", p); end
        nchk++; if (db !== 8'hA5 || !ok) begin nfail++; $display("FAIL single_dv: got byte=%h dv_ok=%0d want A5/1", db, ok); end
        nchk++; if (cnt0 !== CW'(exp_cnt[0])) begin nfail++; $display("FAIL single_cnt0: got %0d want %0d", cnt0, exp_cnt[0]); end
        nchk++; if (ek !== d + GAP + 1) begin nfail++; $display("FAIL single_gap: got idle at %0d want %0d", ek, d + GAP + 1); end
    endtask

    task automatic test_contention();
        int p, ek, erk, ep; logic [7:0] db; bit ok;
        dual = 0;
        for (int i = 0; i < 6; i++) begin
            ep = model_pick(1'b1, 1'b1);
            xfer(1'b1, 1'b1, 8'h11, 8'h22, $urandom_range(1, 5), 1'b1, p, db, ok, ek, erk);
            exp_last = ep; model_done(ep);
            nchk++; if (p !== ep || grant !== ep[0]) begin nfail++; $display("FAIL cont_grant[%0d]: got %0d/%b want %0d", i, p, grant, ep); end
            nchk++; if (db !== (ep == 1 ? 8'h22 : 8'h11) || !ok) begin nfail++; $display("FAIL cont_byte[%0d]: got %h dv_ok=%0d", i, db, ok); end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        nchk++; if (cnt0 !== CW'(exp_cnt[0]) || cnt1 !== CW'(exp_cnt[1])) begin nfail++; $display("FAIL cont_cnt: got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt[0], exp_cnt[1]); end
        nchk++; if (dual !== 0) begin nfail++; $display("FAIL cont_dual_ready: got %0d cycles want 0", dual); end
        step();
    endtask

    task automatic test_random();
        int p, ek, erk, ep, d; logic [7:0] db, b0, b1; bit ok, v0, v1;
        for (int i = 0; i < 10; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            b0 = 8'($urandom); b1 = 8'($urandom);
            d = (i % 4 == 3) ? TO - 1 : $urandom_range(0, 12);
            ep = model_pick(v0, v1);
            xfer(v0, v1, b0, b1, d, 1'b0, p, db, ok, ek, erk);
            exp_last = ep; model_done(ep);
            nchk++; if (p !== ep) begin nfail++; $display("FAIL rand_port[%0d]: got %0d want %0d", i, p, ep); end
            nchk++; if (db !== (ep == 1 ? b1 : b0) || !ok) begin nfail++; $display("FAIL rand_byte[%0d]: got %h dv_ok=%0d", i, db, ok); end
            nchk++; if (ek !== d + GAP + 1 || erk !== -1) begin nfail++; $display("FAIL rand_timing[%0d]: got idle=%0d err=%0d want %0d/-1", i, ek, erk, d + GAP + 1); end
            nchk++; if (cnt0 !== CW'(exp_cnt[0]) || cnt1 !== CW'(exp_cnt[1])) begin nfail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt0, cnt1, exp_cnt[0], exp_cnt[1]); end
        end
        step();
    endtask

    task automatic test_busy_gate();
        int p, ek, erk, seen; logic [7:0] db; bit ok;
        seen = 0;
        bus.tx_active = 1'b1; bus.req1_valid = 1'b1; bus.req1_byte = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.req1_ready !== 1'b0) seen++;
            step();
        end
        nchk++; if (seen !== 0) begin nfail++; $display("FAIL gate_hold: got %0d ready cycles want 0", seen); end
        bus.tx_active = 1'b0;
        #1;
        nchk++; if (bus.req1_ready !== 1'b1) begin nfail++; $display("FAIL gate_release: got %b want 1", bus.req1_ready); end
        xfer(1'b0, 1'b1, 8'h00, 8'h3C, 2, 1'b0, p, db, ok, ek, erk);
        exp_last = 1; model_done(1);
        nchk++; if (p !== 1 || db !== 8'h3C || cnt1 !== CW'(exp_cnt[1])) begin nfail++; $display("FAIL gate_byte: got p=%0d byte=%h cnt1=%0d want 1/3C/%0d", p, db, cnt1, exp_cnt[1]); end
        step();
    endtask

    task automatic test_timeout();
        int p, ek, erk; logic [7:0] db; bit ok;
        xfer(1'b1, 1'b0, 8'h77, 8'h00, -1, 1'b0, p, db, ok, ek, erk);
        exp_last = 0;
        nchk++; if (erk !== TO) begin nfail++; $display("FAIL to_err_time: got %0d want %0d", erk, TO); end
        nchk++; if (ek !== TO + GAP) begin nfail++; $display("FAIL to_idle_time: got %0d want %0d", ek, TO + GAP); end
        nchk++; if (cnt0 !== CW'(exp_cnt[0]) || cnt1 !== CW'(exp_cnt[1])) begin nfail++; $display("FAIL to_cnt: got %0d/%0d want %0d/%0d", cnt0, cnt1, exp_cnt[0], exp_cnt[1]); end
        step();
        clr_err = 1'b1;
        #1;
        nchk++; if (err !== 1'b1) begin nfail++; $display("FAIL to_sticky: got %b want 1", err); end
        step();
        clr_err = 1'b0;
        #1;
        nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL to_clear: got %b want 0", err); end
        xfer(1'b1, 1'b0, 8'h78, 8'h00, 4, 1'b0, p, db, ok, ek, erk);
        model_done(0);
        nchk++; if (db !== 8'h78 || cnt0 !== CW'(exp_cnt[0]) || err !== 1'b0) begin nfail++; $display("FAIL to_next: got byte=%h cnt0=%0d err=%b want 78/%0d/0", db, cnt0, err, exp_cnt[0]); end
        step();
    endtask

    task automatic test_stray();
        int p, ek, erk; logic [7:0] db; bit ok;
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        step();
        #1;
        nchk++; if (cnt0 !== CW'(exp_cnt[0]) || cnt1 !== CW'(exp_cnt[1]) || busy !== 1'b0) begin nfail++; $display("FAIL stray_done: got %0d/%0d busy=%b want %0d/%0d/0", cnt0, cnt1, busy, exp_cnt[0], exp_cnt[1]); end
        xfer(1'b0, 1'b1, 8'h00, 8'h9E, TO - 1, 1'b0, p, db, ok, ek, erk);
        exp_last = 1; model_done(1);
        nchk++; if (cnt1 !== CW'(exp_cnt[1]) || erk !== -1 || err !== 1'b0) begin nfail++; $display("FAIL coincident: got cnt1=%0d err_at=%0d err=%b want %0d/-1/0", cnt1, erk, err, exp_cnt[1]); end
        nchk++; if (ek !== TO + GAP) begin nfail++; $display("FAIL coincident_idle: got %0d want %0d", ek, TO + GAP); end
        step();
    endtask

    task automatic test_reset_busy();
        int p, ek, erk, seen; logic [7:0] db; bit ok;
        bus.req1_valid = 1'b1; bus.req1_byte = 8'h5A;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            #1;
            if (bus.req1_ready === 1'b1) seen = 1;
            step();
        end
        bus.req1_valid = 1'b0;
        repeat (3) step();
        bus.tx_active = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt[0] = 0; exp_cnt[1] = 0; exp_last = 1;
        nchk++; if (seen !== 1 || busy !== 1'b0 || grant !== 1'b0 || bus.tx_byte !== 8'h00 || bus.tx_dv !== 1'b0) begin nfail++; $display("FAIL async_reset: got seen=%0d busy=%b grant=%b byte=%h dv=%b want 1/0/0/00/0", seen, busy, grant, bus.tx_byte, bus.tx_dv); end
        nchk++; if (cnt0 !== '0 || cnt1 !== '0 || err !== 1'b0) begin nfail++; $display("FAIL async_reset_cnt: got %0d/%0d err=%b want 0/0/0", cnt0, cnt1, err); end
        step();
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.req0_byte = 8'hC0; bus.req1_byte = 8'hC1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) seen++;
        end
        nchk++; if (seen !== 0) begin nfail++; $display("FAIL post_reset_gate: got %0d ready cycles want 0", seen); end
        bus.tx_active = 1'b0;
        xfer(1'b1, 1'b1, 8'hC0, 8'hC1, 3, 1'b0, p, db, ok, ek, erk);
        exp_last = 0; model_done(0);
        nchk++; if (p !== 0 || db !== 8'hC0 || cnt0 !== CW'(exp_cnt[0])) begin nfail++; $display("FAIL post_reset_first: got p=%0d byte=%h cnt0=%0d want 0/C0/%0d", p, db, cnt0, exp_cnt[0]); end
        step();
    endtask

    task automatic test_wrap();
        int p, ek, erk; logic [7:0] db; bit ok;
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            xfer(1'b1, 1'b0, 8'(i), 8'h00, 0, 1'b0, p, db, ok, ek, erk);
            exp_last = 0; model_done(0);
            nchk++; if (cnt0 !== CW'(exp_cnt[0])) begin nfail++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", i, cnt0, exp_cnt[0]); end
            step();
        end
        nchk++; if (cnt0 !== '0 || cnt1 !== '0) begin nfail++; $display("FAIL wrap_zero: got %0d/%0d want 0/0", cnt0, cnt1); end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_byte = 8'h00; bus.req1_byte = 8'h00;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_random();
        test_busy_gate();
        test_timeout();
        test_stray();
        test_reset_busy();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
